// File: rtl/counter_ctrl_pkg.sv
// rtl/counter_ctrl_pkg.sv - shared types and constants for the counter step controller
package counter_ctrl_pkg;

    // FSM encodings double as the LED pattern shown on the board
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HOLD = 2'b10,
        ST_LOAD = 2'b11
    } ctrl_state_t;

    localparam int                    STEP_CNT_W          = 8;
    localparam logic [STEP_CNT_W-1:0] STEP_CNT_MAX        = 8'd255;

    // 20 ms debounce and 0.25 s base step period at 50 MHz
    localparam int                    DEF_DEBOUNCE_CYCLES = 1000000;
    localparam int                    DEF_TICK_BASE       = 12500000;

    function automatic logic [STEP_CNT_W-1:0] sat_inc(input logic [STEP_CNT_W-1:0] v);
        return (v == STEP_CNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - push-button synchroniser, debouncer and press detector
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset (already release-synchronised)
//   key_n  raw active-low button, asynchronous to clk
//   press  one-cycle pulse on the debounced 1->0 transition
module key_debounce
    import counter_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic          lvl_q;
    logic          lvl_prev;
    logic [CW-1:0] stab_cnt;

    // Levels start as released, so a key held through reset gives one press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= 1'b1;
            sync2    <= 1'b1;
            lvl_q    <= 1'b1;
            lvl_prev <= 1'b1;
            stab_cnt <= '0;
            press    <= 1'b0;
        end else begin
            sync1    <= key_n;
            sync2    <= sync1;
            lvl_prev <= lvl_q;
            press    <= lvl_prev & ~lvl_q;
            if (sync2 != lvl_q) begin
                if (stab_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    lvl_q    <= sync2;
                    stab_cnt <= '0;
                end else begin
                    stab_cnt <= stab_cnt + 1'b1;
                end
            end else begin
                // any sample agreeing with the current level restarts the count
                stab_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/counter_step_controller.sv
// rtl/counter_step_controller.sv - step/load sequencer for the DE2 3-bit sequence counter
// Ports:
//   CLOCK_50, rst_n          clock and asynchronous active-low reset
//   key_step_n, key_load_n   raw active-low push buttons
//   run_en, rate_sel         auto-run request and period select (TICK_BASE >> rate_sel)
//   stop_en, stop_val        hold when cnt_q reaches stop_val during auto-run
//   load_val, cnt_q          value to load, counter feedback
//   step_en, load_en, load_d one-cycle counter commands and load data
//   step_count, state        saturating steps since last load, FSM state for LEDs
module counter_step_controller
    import counter_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int TICK_BASE       = DEF_TICK_BASE
) (
    input  logic                  CLOCK_50,
    input  logic                  rst_n,
    input  logic                  key_step_n,
    input  logic                  key_load_n,
    input  logic                  run_en,
    input  logic [1:0]            rate_sel,
    input  logic                  stop_en,
    input  logic [2:0]            stop_val,
    input  logic [2:0]            load_val,
    input  logic [2:0]            cnt_q,
    output logic                  step_en,
    output logic                  load_en,
    output logic [2:0]            load_d,
    output logic [STEP_CNT_W-1:0] step_count,
    output logic [1:0]            state
);

    localparam int PW = $clog2(TICK_BASE + 1);

    logic          [1:0]    rst_pipe;
    logic                   rst_int;
    logic                   step_press;
    logic                   load_press;
    ctrl_state_t            state_q;
    ctrl_state_t            state_nxt;
    logic                   step_nxt;
    logic                   load_nxt;
    logic                   stop_hit;
    logic                   tick;
    logic          [PW-1:0] presc;
    logic          [PW-1:0] period;

    // Reset asserts immediately and releases two clocks after rst_n rises.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            rst_pipe <= 2'b00;
        end else begin
            rst_pipe <= {rst_pipe[0], 1'b1};
        end
    end
    assign rst_int = rst_pipe[1];

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_key (
        .clk   (CLOCK_50),
        .rst_n (rst_int),
        .key_n (key_step_n),
        .press (step_press)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load_key (
        .clk   (CLOCK_50),
        .rst_n (rst_int),
        .key_n (key_load_n),
        .press (load_press)
    );

    assign stop_hit = stop_en && (cnt_q == stop_val);
    assign tick     = (state_q == ST_RUN) && (presc == period - 1'b1);

    // State register, registered outputs, prescaler and step counter
    always_ff @(posedge CLOCK_50 or negedge rst_int) begin
        if (!rst_int) begin
            state_q    <= ST_IDLE;
            step_en    <= 1'b0;
            load_en    <= 1'b0;
            load_d     <= 3'd0;
            step_count <= '0;
            presc      <= '0;
            period     <= PW'(TICK_BASE);
        end else begin
            state_q <= state_nxt;
            step_en <= step_nxt;
            load_en <= load_nxt;
            if (load_nxt) begin
                load_d     <= load_val;
                step_count <= '0;
            end else if (step_en) begin
                step_count <= sat_inc(step_count);
            end
            // rate_sel is only looked at when a period starts
            if ((state_q == ST_RUN) && (state_nxt == ST_RUN)) begin
                if (tick) begin
                    presc  <= '0;
                    period <= PW'(TICK_BASE >> rate_sel);
                end else begin
                    presc <= presc + 1'b1;
                end
            end else begin
                presc  <= '0;
                period <= PW'(TICK_BASE >> rate_sel);
            end
        end
    end

    // Next state: load press beats run/stop, which beat step/tick
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE: begin
                if (load_press)  state_nxt = ST_LOAD;
                else if (run_en) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (load_press)            state_nxt = ST_LOAD;
                else if (!run_en)          state_nxt = ST_IDLE;
                else if (tick && stop_hit) state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (load_press)      state_nxt = ST_LOAD;
                else if (!run_en)    state_nxt = ST_IDLE;
                else if (step_press) state_nxt = ST_RUN;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output commands, registered next cycle
    always_comb begin
        step_nxt = 1'b0;
        case (state_q)
            ST_IDLE: step_nxt = step_press && !load_press && !run_en;
            ST_RUN:  step_nxt = tick && !stop_hit && run_en && !load_press;
            ST_HOLD: step_nxt = step_press && run_en && !load_press;
            default: step_nxt = 1'b0;
        endcase
        load_nxt = (state_nxt == ST_LOAD);
    end

    assign state = state_q;

endmodule

// File: doc/counter_step_controller.md
Name: counter_step_controller

Overview:
Sequencer for the 3-bit D-flip-flop sequence counter on the DE2 board. It turns raw push buttons and switches into clean one-cycle `step_en` and `load_en` commands for the counter. It supports manual single-step, timed auto-run and stop-at-value hold modes, and it keeps a saturating count of steps since the last load, which feeds binary_to_BCD for the HEX display.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive stable samples required to accept a key level change (20 ms at 50 MHz)
TICK_BASE, 12500000, auto-run step period in cycles at rate_sel=0 (0.25 s)

Ports:
CLOCK_50  in  1  system clock, 50 MHz
rst_n  in  1  asynchronous active-low reset
key_step_n  in  1  raw step push button, active-low, asynchronous
key_load_n  in  1  raw load push button, active-low, asynchronous
run_en  in  1  switch: 1 = auto-run requested
rate_sel  in  2  auto-run period = TICK_BASE >> rate_sel
stop_en  in  1  enables hold when cnt_q == stop_val
stop_val  in  3  hold target value
load_val  in  3  value to load into the counter
cnt_q  in  3  current counter output (feedback)
step_en  out  1  one-cycle pulse: advance counter
load_en  out  1  one-cycle pulse: load load_d
load_d  out  3  load value, valid while load_en=1
step_count  out  8  steps since last load, saturating
state  out  2  FSM state for LED display

Behaviour:
- Reset (async assert, sync-safe deassert internally):
  - state=IDLE, step_en=0, load_en=0, load_d=0, step_count=0, prescaler=0.
  - Debounced key levels initialise to released (1).
- Key path, per key:
  - 2-FF synchroniser feeds a stability counter.
  - The debounced level updates after DEBOUNCE_CYCLES consecutive samples that differ from the current level. Any mismatch restarts the count.
  - A press event is a one-cycle pulse on the debounced 1->0 transition.
  - Latency from a clean edge to the press pulse is 2 + DEBOUNCE_CYCLES + 1 cycles.
  - A key held through reset release yields exactly one press.
- Prescaler:
  - Counts 0..P-1, where P = TICK_BASE >> rate_sel; tick is asserted at P-1.
  - Cleared on entry to RUN.
  - rate_sel is sampled only at wrap, so a change takes effect on the next period.
  - Idle outside RUN.
- FSM, evaluated every cycle in priority order: load press > run_en/stop > step/tick.
  - IDLE (00):
    - load press -> LOAD.
    - else run_en=1 -> RUN.
    - else step press -> step_en pulse, stay IDLE.
  - RUN (01):
    - load press -> LOAD.
    - else run_en=0 -> IDLE.
    - else on tick: if stop_en=1 and cnt_q==stop_val -> HOLD with no step; otherwise step_en pulse.
    - Manual step presses are ignored in RUN.
  - HOLD (10):
    - load press -> LOAD.
    - else run_en=0 -> IDLE.
    - else step press -> one step_en pulse and return to RUN (prescaler cleared).
  - LOAD (11), exactly one cycle:
    - load_en=1; load_d = load_val captured in the press cycle.
    - step_count cleared to 0.
    - Next state is IDLE.
- All outputs are registered.
  - step_en and load_en are never high together.
  - A tick coincident with a load press is discarded.
- step_count increments in the cycle step_en is driven; the new value is visible on the following cycle. It saturates at 255.
- Async reset mid-operation: outputs go to reset values immediately. Any pulse in flight is dropped.

Decomposition:
- Package counter_ctrl_pkg holds:
  - state encodings IDLE/RUN/HOLD/LOAD (2-bit);
  - step_count width (8) and saturation value 255;
  - default DEBOUNCE_CYCLES and TICK_BASE constants.
- One sub-module, key_debounce (synchroniser + stability counter + press pulse), instantiated twice: step key and load key.
- The FSM, prescaler and step counter stay in the top module.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, TICK_BASE=16.
1. Reset, load_val=5, key_load_n low 12 cycles -> exactly one load_en pulse with load_d=5; step_count=0; state LOAD then IDLE.
2. key_step_n toggling every 2 cycles for 20 cycles, then held low -> exactly one step_en pulse; step_count=1; no pulse on release.
3. run_en=1, rate_sel=0 -> step_en every 16 cycles. Set rate_sel=2 mid-period -> after the next wrap, step_en every 4 cycles.
4. RUN with stop_en=1, stop_val=3, cnt_q forced to 3 -> next tick enters HOLD with no step_en and no further pulses. Step press -> one step_en, state RUN.
5. Load press timed so its press pulse coincides with a RUN tick -> load_en only, no step_en; step_count=0; state IDLE while run_en=1 then RUN next cycle.
6. 300 manual steps -> step_count=255. Assert rst_n low mid-RUN -> all outputs 0 within the same cycle; after release state=IDLE.
